// File: rtl/wr_color_if.sv
// rtl/wr_color_if.sv - MIG user write-burst bundle between the colour-bar writer and the DDR controller
interface wr_color_if;
  logic         wr_req;
  logic [27:0]  wr_req_addr;
  logic [15:0]  wr_length;
  logic [127:0] wr_data;
  logic         wr_busy;
  logic         wr_data_req;
  logic         wr_done;

  modport master (
    output wr_req, wr_req_addr, wr_length, wr_data,
    input  wr_busy, wr_data_req, wr_done
  );

  modport slave (
    input  wr_req, wr_req_addr, wr_length, wr_data,
    output wr_busy, wr_data_req, wr_done
  );
endinterface

// File: rtl/wr_color.sv
// rtl/wr_color.sv - writes a colour-bar frame into DDR one line-burst at a time
// 128-bit beats carry four 32-bit {00,R,G,B} pixels, leftmost pixel in the top word.
module wr_color #(
  parameter int H_PIXELS    = 1280,
  parameter int V_LINES     = 720,
  parameter int LINE_STRIDE = 2560,
  parameter int BASE_ADDR   = 0,
  parameter int LOOP        = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_done,
  wr_color_if.master  bus,
  output logic        frame_done,
  output logic        frame_valid,
  output logic        err
);

  localparam int BEATS = H_PIXELS / 4;
  localparam int BAR_W = H_PIXELS / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_DATA, S_WAIT, S_NEXT, S_HALT
  } state_t;

  state_t        state_q;
  logic [15:0]   beat_q;
  logic [15:0]   line_q;
  logic [27:0]   addr_q;
  logic [127:0]  data_q;
  logic          req_q;
  logic          fdone_q;
  logic          fvalid_q;
  logic          err_q;

  function automatic logic [31:0] bar_word(input logic [15:0] x);
    logic [15:0] bar;
    logic [31:0] w;
    bar = x / 16'(BAR_W);
    if (bar > 16'd7) bar = 16'd7;
    case (bar[2:0])
      3'd0:    w = 32'h00FF_FFFF;
      3'd1:    w = 32'h00FF_FF00;
      3'd2:    w = 32'h0000_FFFF;
      3'd3:    w = 32'h0000_FF00;
      3'd4:    w = 32'h00FF_00FF;
      3'd5:    w = 32'h00FF_0000;
      3'd6:    w = 32'h0000_00FF;
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  // Every slot uses its own x so a bar edge inside a beat is still exact.
  function automatic logic [127:0] beat_pixels(input logic [15:0] b);
    logic [127:0] w;
    logic [15:0]  x;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      x = {b[13:0], 2'b00} + 16'(k);
      w[127-32*k -: 32] = bar_word(x);
    end
    return w;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      line_q   <= '0;
      addr_q   <= 28'(BASE_ADDR);
      data_q   <= '0;
      req_q    <= 1'b0;
      fdone_q  <= 1'b0;
      fvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      req_q   <= 1'b0;
      fdone_q <= 1'b0;
      if (bus.wr_data_req && state_q != S_DATA) err_q <= 1'b1;
      if (bus.wr_done && (state_q == S_IDLE || state_q == S_REQ)) err_q <= 1'b1;

      case (state_q)
        S_IDLE: if (init_done) state_q <= S_REQ;

        S_REQ: if (!bus.wr_busy) begin
          req_q   <= 1'b1;
          beat_q  <= '0;
          data_q  <= beat_pixels(16'd0);
          state_q <= S_DATA;
        end

        S_DATA: begin
          if (bus.wr_data_req) begin
            beat_q <= beat_q + 16'd1;
            data_q <= beat_pixels(beat_q + 16'd1);
            if (beat_q == 16'(BEATS - 1)) begin
              state_q <= bus.wr_done ? S_NEXT : S_WAIT;
            end else if (bus.wr_done) begin
              err_q   <= 1'b1;
              state_q <= S_NEXT;
            end
          end else if (bus.wr_done) begin
            // Controller closed the burst early: flag it and move on.
            err_q   <= 1'b1;
            state_q <= S_NEXT;
          end
        end

        S_WAIT: if (bus.wr_done) state_q <= S_NEXT;

        S_NEXT: begin
          beat_q <= '0;
          if (line_q == 16'(V_LINES - 1)) begin
            line_q   <= '0;
            addr_q   <= 28'(BASE_ADDR);
            fdone_q  <= 1'b1;
            fvalid_q <= 1'b1;
            state_q  <= (LOOP != 0) ? S_REQ : S_HALT;
          end else begin
            line_q  <= line_q + 16'd1;
            addr_q  <= addr_q + 28'(LINE_STRIDE);
            state_q <= S_REQ;
          end
        end

        S_HALT: state_q <= S_HALT;

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.wr_req      = req_q;
  assign bus.wr_req_addr = addr_q;
  assign bus.wr_length   = 16'(BEATS);
  assign bus.wr_data     = data_q;
  assign frame_done      = fdone_q;
  assign frame_valid     = fvalid_q;
  assign err             = err_q;

endmodule

// File: tb/tb_wr_color.sv
// tb/tb_wr_color.sv - directed bench: one full-width writer for beat/handshake cases, two narrow ones for whole frames
module tb_wr_color;
  localparam int HA = 1280;
  localparam int VA = 4;
  localparam int HS = 32;
  localparam int VS = 720;
  localparam int STRIDE = 2560;

  localparam logic [31:0] COLORS [8] = '{
    32'h00FFFFFF, 32'h00FFFF00, 32'h0000FFFF, 32'h0000FF00,
    32'h00FF00FF, 32'h00FF0000, 32'h000000FF, 32'h00000000
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_a = 1'b0;
  logic init_s = 1'b0;
  logic fd_a, fv_a, err_a, fd_b, fv_b, err_b, fd_c, fv_c, err_c;

  int total = 0;
  int bad = 0;
  int req_b = 0;
  int fdb = 0;
  int fdc = 0;
  bit errc_seen = 1'b0;

  wr_color_if ia();
  wr_color_if ib();
  wr_color_if ic();

  wr_color #(.H_PIXELS(HA), .V_LINES(VA), .LINE_STRIDE(STRIDE), .BASE_ADDR(0), .LOOP(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .init_done(init_a), .bus(ia),
    .frame_done(fd_a), .frame_valid(fv_a), .err(err_a));
  wr_color #(.H_PIXELS(HS), .V_LINES(VS), .LINE_STRIDE(STRIDE), .BASE_ADDR(0), .LOOP(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .init_done(init_s), .bus(ib),
    .frame_done(fd_b), .frame_valid(fv_b), .err(err_b));
  wr_color #(.H_PIXELS(HS), .V_LINES(VS), .LINE_STRIDE(STRIDE), .BASE_ADDR(0), .LOOP(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .init_done(init_s), .bus(ic),
    .frame_done(fd_c), .frame_valid(fv_c), .err(err_c));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ib.wr_req) req_b <= req_b + 1;
    if (fd_b) fdb <= fdb + 1;
    if (fd_c) fdc <= fdc + 1;
    if (err_c) errc_seen <= 1'b1;
  end

  function automatic logic [127:0] exp_beat(input int b, input int barw);
    logic [127:0] w;
    int bar;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      bar = (4 * b + k) / barw;
      if (bar > 7) bar = 7;
      w[127-32*k -: 32] = COLORS[bar];
    end
    return w;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req_a(output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick;
      cyc++;
      if (ia.wr_req) ok = 1'b1;
    end
  endtask

  task automatic done_a;
    ia.wr_done = 1'b1;
    tick;
    ia.wr_done = 1'b0;
  endtask

  task automatic stream_a(input int n, input bit chk);
    int idx = 0;
    int guard = 0;
    logic g;
    logic [127:0] e;
    while (idx < n && guard < 4000) begin
      g = ($urandom_range(0, 3) != 0);
      ia.wr_data_req = g;
      if (g && chk) begin
        e = exp_beat(idx, HA / 8);
        total++;
        if (ia.wr_data !== e) begin
          bad++;
          $display("FAIL beat%0d got=%h want=%h", idx, ia.wr_data, e);
        end
        if (idx == 40) begin
          total++;
          if (ia.wr_data !== {4{32'h00FFFF00}}) begin
            bad++;
            $display("FAIL beat40 got=%h want=%h", ia.wr_data, {4{32'h00FFFF00}});
          end
        end
        if (idx == 319) begin
          total++;
          if (ia.wr_data !== 128'h0) begin
            bad++;
            $display("FAIL beat319 got=%h want=0", ia.wr_data);
          end
        end
      end
      tick;
      guard++;
      if (g) idx++;
    end
    ia.wr_data_req = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    init_a = 1'b0;
    init_s = 1'b0;
    repeat (3) tick;
    total++;
    if (ia.wr_req !== 1'b0 || ia.wr_req_addr !== 28'd0 || ia.wr_data !== 128'h0) begin
      bad++;
      $display("FAIL reset_bus req=%b addr=%0d data=%h want 0/0/0", ia.wr_req, ia.wr_req_addr, ia.wr_data);
    end
    total++;
    if (ia.wr_length !== 16'd320) begin
      bad++;
      $display("FAIL reset_len got=%0d want=320", ia.wr_length);
    end
    total++;
    if ({fd_a, fv_a, err_a} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000", {fd_a, fv_a, err_a});
    end
  endtask

  task automatic test_first_line;
    bit ok;
    int cyc;
    rst_n = 1'b1;
    init_a = 1'b1;
    wait_req_a(ok, cyc);
    total++;
    if (!ok || cyc != 2) begin
      bad++;
      $display("FAIL first_req_latency ok=%b cycles=%0d want 2", ok, cyc);
    end
    total++;
    if (ia.wr_req_addr !== 28'd0 || ia.wr_length !== 16'd320) begin
      bad++;
      $display("FAIL first_req_addr addr=%0d len=%0d want 0/320", ia.wr_req_addr, ia.wr_length);
    end
    total++;
    if (ia.wr_data[127:96] !== 32'h00FFFFFF || ia.wr_data[31:0] !== 32'h00FFFFFF) begin
      bad++;
      $display("FAIL beat0_words got=%h/%h want 00ffffff", ia.wr_data[127:96], ia.wr_data[31:0]);
    end
    tick;
    total++;
    if (ia.wr_req !== 1'b0) begin
      bad++;
      $display("FAIL req_one_cycle got=%b want=0", ia.wr_req);
    end
    stream_a(320, 1'b1);
    total++;
    if (err_a !== 1'b0) begin
      bad++;
      $display("FAIL line0_err got=%b want=0", err_a);
    end
  endtask

  task automatic test_busy;
    bit ok;
    int cyc;
    int n = 0;
    ia.wr_busy = 1'b1;
    done_a;
    repeat (50) begin
      tick;
      if (ia.wr_req) n++;
    end
    total++;
    if (n != 0) begin
      bad++;
      $display("FAIL busy_hold reqs=%0d want=0", n);
    end
    ia.wr_busy = 1'b0;
    wait_req_a(ok, cyc);
    total++;
    if (!ok || ia.wr_req_addr !== 28'd2560) begin
      bad++;
      $display("FAIL line1_addr ok=%b addr=%0d want 2560", ok, ia.wr_req_addr);
    end
    n = 0;
    repeat (5) begin
      tick;
      if (ia.wr_req) n++;
    end
    total++;
    if (n != 0) begin
      bad++;
      $display("FAIL busy_single_pulse extra=%0d want=0", n);
    end
    stream_a(320, 1'b0);
    done_a;
  endtask

  task automatic test_stray_wait;
    bit ok;
    int cyc;
    wait_req_a(ok, cyc);
    total++;
    if (!ok || ia.wr_req_addr !== 28'd5120) begin
      bad++;
      $display("FAIL line2_addr ok=%b addr=%0d want 5120", ok, ia.wr_req_addr);
    end
    stream_a(320, 1'b0);
    total++;
    if (err_a !== 1'b0) begin
      bad++;
      $display("FAIL pre_stray_err got=%b want=0", err_a);
    end
    ia.wr_data_req = 1'b1;
    tick;
    ia.wr_data_req = 1'b0;
    total++;
    if (err_a !== 1'b1) begin
      bad++;
      $display("FAIL stray_wait_err got=%b want=1", err_a);
    end
    done_a;
    wait_req_a(ok, cyc);
    total++;
    if (!ok || ia.wr_req_addr !== 28'd7680 || err_a !== 1'b1) begin
      bad++;
      $display("FAIL line3_addr ok=%b addr=%0d err=%b want 7680 err 1", ok, ia.wr_req_addr, err_a);
    end
  endtask

  task automatic test_early_done;
    bit ok;
    int cyc;
    rst_n = 1'b0;
    tick;
    total++;
    if (err_a !== 1'b0) begin
      bad++;
      $display("FAIL err_cleared got=%b want=0", err_a);
    end
    rst_n = 1'b1;
    wait_req_a(ok, cyc);
    total++;
    if (!ok || ia.wr_req_addr !== 28'd0) begin
      bad++;
      $display("FAIL rerun_addr ok=%b addr=%0d want 0", ok, ia.wr_req_addr);
    end
    stream_a(100, 1'b0);
    done_a;
    total++;
    if (err_a !== 1'b1) begin
      bad++;
      $display("FAIL early_done_err got=%b want=1", err_a);
    end
    wait_req_a(ok, cyc);
    total++;
    if (!ok || ia.wr_req_addr !== 28'd2560) begin
      bad++;
      $display("FAIL early_done_advance ok=%b addr=%0d want 2560", ok, ia.wr_req_addr);
    end
  endtask

  task automatic test_reset_mid;
    stream_a(50, 1'b0);
    total++;
    if (ia.wr_data !== {4{32'h00FFFF00}}) begin
      bad++;
      $display("FAIL beat50 got=%h want=%h", ia.wr_data, {4{32'h00FFFF00}});
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (ia.wr_data !== 128'h0 || ia.wr_req_addr !== 28'd0 || ia.wr_req !== 1'b0 || {fd_a, fv_a, err_a} !== 3'b000) begin
      bad++;
      $display("FAIL async_reset data=%h addr=%0d req=%b flags=%b want all 0", ia.wr_data, ia.wr_req_addr, ia.wr_req, {fd_a, fv_a, err_a});
    end
    init_a = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_frames;
    bit ok;
    bit use_b;
    bit both;
    init_s = 1'b1;
    for (int line = 0; line < 2 * VS; line++) begin
      use_b = (line < VS);
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
        tick;
        if (ic.wr_req) ok = 1'b1;
      end
      if (!ok) begin
        total++;
        bad++;
        $display("FAIL frame_req_timeout line=%0d", line);
        break;
      end
      if (line == VS - 1) begin
        total++;
        if (ib.wr_req !== 1'b1 || ib.wr_req_addr !== 28'd1840640 || fv_b !== 1'b0) begin
          bad++;
          $display("FAIL last_line_b req=%b addr=%0d fv=%b want 1/1840640/0", ib.wr_req, ib.wr_req_addr, fv_b);
        end
      end
      if (line == VS) begin
        total++;
        if (ic.wr_req_addr !== 28'd0 || fv_c !== 1'b1) begin
          bad++;
          $display("FAIL loop_wrap addr=%0d fv=%b want 0/1", ic.wr_req_addr, fv_c);
        end
      end
      if (line == 2 * VS - 1) begin
        total++;
        if (ic.wr_req_addr !== 28'd1840640) begin
          bad++;
          $display("FAIL loop_last addr=%0d want 1840640", ic.wr_req_addr);
        end
      end
      // Odd lines finish with data_req and wr_done on the same last beat.
      both = (line % 2 == 1);
      for (int b = 0; b < HS / 4; b++) begin
        ib.wr_data_req = use_b;
        ic.wr_data_req = 1'b1;
        if (both && b == HS / 4 - 1) begin
          ib.wr_done = use_b;
          ic.wr_done = 1'b1;
        end
        tick;
      end
      ib.wr_data_req = 1'b0;
      ic.wr_data_req = 1'b0;
      if (!both) begin
        ib.wr_done = use_b;
        ic.wr_done = 1'b1;
        tick;
      end
      ib.wr_done = 1'b0;
      ic.wr_done = 1'b0;
    end
    repeat (50) tick;
    total++;
    if (fdb != 1 || fv_b !== 1'b1 || err_b !== 1'b0) begin
      bad++;
      $display("FAIL frame_b fdone=%0d fv=%b err=%b want 1/1/0", fdb, fv_b, err_b);
    end
    total++;
    if (req_b != VS) begin
      bad++;
      $display("FAIL halt_reqs got=%0d want=%0d", req_b, VS);
    end
    total++;
    if (fdc != 2 || errc_seen !== 1'b0) begin
      bad++;
      $display("FAIL loop_c fdone=%0d err_seen=%b want 2/0", fdc, errc_seen);
    end
  endtask

  initial begin
    ia.wr_busy = 1'b0; ia.wr_data_req = 1'b0; ia.wr_done = 1'b0;
    ib.wr_busy = 1'b0; ib.wr_data_req = 1'b0; ib.wr_done = 1'b0;
    ic.wr_busy = 1'b0; ic.wr_data_req = 1'b0; ic.wr_done = 1'b0;
    test_reset;
    test_first_line;
    test_busy;
    test_stray_wait;
    test_early_done;
    test_reset_mid;
    test_frames;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
